// File: rtl/sc_store_writer_pkg.sv
// Shared types and helpers for the store-side data path: size codes, writer
// FSM states and the alignment legality check (also used by the load side).
package sc_store_writer_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } st_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_e;

  // An access is legal only if it is naturally aligned to its own size.
  function automatic logic is_misaligned(input st_size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sc_store_align.sv
// Places store data onto memory byte lanes and derives byte enables for
// byte/half/word accesses; flags accesses that are not naturally aligned.
module sc_store_align
  import sc_store_writer_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  st_size_e size;
  assign size = st_size_e'(size_i);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = data_i;
    misaligned_o = is_misaligned(size, addr_lo_i);
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = data_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/sc_store_writer.sv
// Store writer: accepts a store from the control unit, drives one aligned
// req/ack write to data memory and reports done, or error on bad access/timeout.
module sc_store_writer
  import sc_store_writer_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_start,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_misaligned;

  sc_store_align u_align (
    .size_i       (st_size),
    .addr_lo_i    (st_addr[1:0]),
    .data_i       (st_data),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_misaligned)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (st_start) begin
          if (al_misaligned) begin
            state_d = S_ERR;
          end else begin
            // Memory-side outputs only change on an accepted store.
            state_d = S_REQ;
            cnt_d   = '0;
            addr_d  = {st_addr[31:2], 2'b00};
            wdata_d = al_wdata;
            be_d    = al_be;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (TIMEOUT_EN && (cnt_d == TIMEOUT_C)) begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign st_busy   = (state_q != S_IDLE);
  assign st_done   = (state_q == S_DONE);
  assign st_err    = (state_q == S_ERR);
  assign mem_req   = (state_q == S_REQ);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  a_done_err_excl: assert property (@(posedge clk) disable iff (rst) !(st_done && st_err));

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_ack) |=> (mem_addr == $past(mem_addr) && mem_be == $past(mem_be)
                               && mem_wdata == $past(mem_wdata)));

endmodule

// File: tb/tb_sc_store_writer.sv
// Scoreboard bench for sc_store_writer: the driver pushes the expected outcome
// of each store; a negedge monitor checks bus contents and pops on done/err.
module tb_sc_store_writer;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  typedef struct {
    logic        is_err;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_start;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   req_cnt  = 0;

  sc_store_writer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_start  (st_start),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] data, input int ack_dly);
    exp_t e;
    logic bad;
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    e.addr = addr & 32'hFFFF_FFFC;
    case (size)
      2'b00: begin
        e.be    = 4'b0001 << addr[1:0];
        e.wdata = {data[7:0], data[7:0], data[7:0], data[7:0]};
      end
      2'b01: begin
        e.be    = addr[1] ? 4'b1100 : 4'b0011;
        e.wdata = {data[15:0], data[15:0]};
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = data;
      end
    endcase
    e.is_err     = bad || (ack_dly == 0);
    e.req_cycles = bad ? 0 : ((ack_dly == 0) ? TIMEOUT : ack_dly);
    return e;
  endfunction

  // Monitor: field checks while mem_req is up, outcome checks on done/err.
  always @(negedge clk) begin
    if (rst) begin
      req_cnt = 0;
    end else begin
      if (mem_req) begin
        req_cnt++;
        if (sb.size() == 0) begin
          check("req_unexpected", 32'(mem_req), 32'd0);
        end else begin
          check("mem_addr", mem_addr, sb[0].addr);
          check("mem_be", 32'(mem_be), 32'(sb[0].be));
          check("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end
      if (st_done || st_err) begin
        check("done_err_excl", 32'(st_done && st_err), 32'd0);
        if (sb.size() == 0) begin
          check("out_unexpected", {30'd0, st_done, st_err}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("outcome_err", 32'(st_err), 32'(e.is_err));
          check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
        end
        req_cnt = 0;
      end
    end
  end

  // Issues one store; returns one step after the ack edge (or the accept edge
  // when no ack is given), so a follow-up call lands right after DONE -> IDLE.
  task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] data, input int ack_dly, input logic poke);
    exp_t e;
    e = model(size, addr, data, ack_dly);
    sb.push_back(e);
    @(posedge clk); #1;
    st_start = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
    @(posedge clk); #1;
    st_start = poke;
    if (poke) begin
      st_size = 2'b10;
      st_addr = 32'hFFFF_FFF0;
      st_data = 32'h1234_5678;
    end
    if (e.is_err && e.req_cycles == 0) begin
      check("err_immediate", 32'(st_err), 32'd1);
      check("err_no_req", 32'(mem_req), 32'd0);
    end
    if (ack_dly > 0) begin
      for (int i = 1; i < ack_dly; i++) begin
        @(posedge clk); #1;
        st_start = 1'b0;
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack  = 1'b0;
      st_start = 1'b0;
      if (!e.is_err) check("done_after_ack", 32'(st_done), 32'd1);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    st_start = 1'b0;
    st_size  = 2'b00;
    st_addr  = '0;
    st_data  = '0;
    mem_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(st_busy), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done_err", {30'd0, st_done, st_err}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Word store, ack three cycles after accept.
    do_store(2'b10, 32'h0000_1004, 32'hDEAD_BEEF, 3, 1'b0);
    wait_drain();
    check("hold_addr", mem_addr, 32'h0000_1004);
    check("hold_wdata", mem_wdata, 32'hDEAD_BEEF);

    // Byte store in the top lane, immediate ack.
    do_store(2'b00, 32'h0000_2003, 32'h0000_00A5, 1, 1'b0);
    wait_drain();

    // Halfword in the upper half.
    do_store(2'b01, 32'h0000_3002, 32'h0000_BEEF, 2, 1'b0);
    wait_drain();

    // Illegal accesses; bus outputs must keep the last legal store.
    do_store(2'b01, 32'h0000_0001, 32'h1111_1111, 0, 1'b0);
    wait_drain();
    do_store(2'b10, 32'h0000_1002, 32'h2222_2222, 0, 1'b0);
    wait_drain();
    do_store(2'b11, 32'h0000_0100, 32'h3333_3333, 0, 1'b0);
    wait_drain();
    check("hold_be_after_err", 32'(mem_be), 32'h0000_000C);

    // Timeout, then ack exactly on the last allowed edge.
    do_store(2'b10, 32'h0000_7000, 32'h0BAD_CAFE, 0, 1'b0);
    wait_drain();
    check("idle_after_timeout", 32'(st_busy), 32'd0);
    do_store(2'b00, 32'h0000_7001, 32'h0000_005C, TIMEOUT, 1'b0);
    wait_drain();

    // Reset in the middle of a request.
    sb.push_back(model(2'b10, 32'h0000_5008, 32'hCAFE_F00D, 5));
    @(posedge clk); #1;
    st_start = 1'b1;
    st_size  = 2'b10;
    st_addr  = 32'h0000_5008;
    st_data  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    st_start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(st_busy), 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_be", 32'(mem_be), 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    check("midrst_done_err", {30'd0, st_done, st_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_store(2'b10, 32'h0000_6000, 32'h0102_0304, 2, 1'b0);
    wait_drain();

    // Back-to-back: start during busy is ignored, next start right after DONE.
    do_store(2'b10, 32'h0000_4000, 32'h1111_2222, 2, 1'b1);
    do_store(2'b00, 32'h0000_4001, 32'h0000_0033, 1, 1'b0);
    wait_drain();

    // Ack outside REQ must not start or complete anything.
    @(posedge clk); #1;
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("stray_ack_busy", 32'(st_busy), 32'd0);
    check("stray_ack_addr", mem_addr, 32'h0000_4000);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
